udp_rx_pkt_sched: RTL

UDP_RX_PKT_SCHED -- requirements
Module: udp_rx_pkt_sched

---
 rtl/udp_rx_pkt_sched_if.sv | 25 ++
 rtl/udp_rx_pkt_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_pkt_sched_if.sv
// Output byte stream of the UDP receive packet scheduler.
// master = scheduler side, slave = downstream consumer.
interface udp_rx_pkt_sched_if;
  logic        o_pkt_valid;
  logic        i_pkt_ready;
  logic [7:0]  o_pkt_data;
  logic        o_pkt_last;
  logic [15:0] o_pkt_len;

  modport master (
    output o_pkt_valid,
    output o_pkt_data,
    output o_pkt_last,
    output o_pkt_len,
    input  i_pkt_ready
  );

  modport slave (
    input  o_pkt_valid,
    input  o_pkt_data,
    input  o_pkt_last,
    input  o_pkt_len,
    output i_pkt_ready
  );
endinterface

// File: rtl/udp_rx_pkt_sched.sv
// UDP receive packet scheduler: ping-pong buffering of received payloads.
// A frame is written into a free bank and committed only if its length
// matches the announced length. Committed banks are replayed in commit order
// on a valid/ready byte stream with registered outputs.
module udp_rx_pkt_sched #(
  parameter int MAX_LEN = 1024,
  parameter int ADDR_W  = 10
) (
  input  logic                       i_gmii_rx_clk,
  input  logic                       i_sys_rstn,
  input  logic                       i_rec_dvalid,
  input  logic [7:0]                 i_rec_data,
  input  logic [15:0]                i_rec_data_num,
  input  logic                       i_udp_rec_done,
  udp_rx_pkt_sched_if.master         pkt,
  output logic [15:0]                o_drop_cnt,
  output logic [15:0]                o_err_cnt,
  output logic [1:0]                 o_bank_full
);

  localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_FILL = 2'd1, W_DROP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_LOAD = 2'd1, R_SEND = 2'd2} r_state_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  logic [7:0]        mem_r [0:1][0:MAX_LEN-1];
  logic [1:0]        full_r;
  logic [15:0]       len_r [0:1];
  logic              wr_bank_r;
  logic              rd_bank_r;
  logic [15:0]       wcnt_r;
  logic              ovf_r;
  logic              done_d_r;
  logic              done_evt_s;
  logic [15:0]       drop_cnt_r;
  logic [15:0]       err_cnt_r;

  w_state_t          w_st_r, w_nxt_s;
  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [15:0]       wcnt_nxt_s;
  logic              ovf_nxt_s;
  logic              commit_s;
  logic              err_s;
  logic              drop_s;

  r_state_t          r_st_r, r_nxt_s;
  logic              ren_s;
  logic [15:0]       raddr_s;
  logic [15:0]       rptr_r, rptr_nxt_s;
  logic              start_s;
  logic              release_s;
  logic              valid_r, valid_nxt_s;
  logic              last_r;
  logic              last_s;
  logic [7:0]        rdata_r;
  logic [15:0]       pkt_len_r;

  assign done_evt_s = i_udp_rec_done & ~done_d_r;

  // Previous level of the done input, used to see only its rising edge.
  always_ff @(posedge i_gmii_rx_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      done_d_r <= 1'b0;
    end else begin
      done_d_r <= i_udp_rec_done;
    end
  end

  // Write FSM state register.
  always_ff @(posedge i_gmii_rx_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      w_st_r <= W_IDLE;
    end else begin
      w_st_r <= w_nxt_s;
    end
  end

  // Write FSM next state and per-byte write/commit decisions.
  always_comb begin
    w_nxt_s    = w_st_r;
    we_s       = 1'b0;
    waddr_s    = {ADDR_W{1'b0}};
    wcnt_nxt_s = wcnt_r;
    ovf_nxt_s  = ovf_r;
    commit_s   = 1'b0;
    err_s      = 1'b0;
    drop_s     = 1'b0;
    case (w_st_r)
      W_IDLE: begin
        // A done edge here means a zero-length frame: nothing to do.
        if (i_rec_dvalid) begin
          if (!full_r[wr_bank_r]) begin
            we_s       = 1'b1;
            wcnt_nxt_s = 16'd1;
            w_nxt_s    = W_FILL;
          end else begin
            drop_s  = 1'b1;
            w_nxt_s = W_DROP;
          end
        end else begin
          w_nxt_s = W_IDLE;
        end
      end
      W_FILL: begin
        if (done_evt_s) begin
          if ((wcnt_r == i_rec_data_num) && !ovf_r) begin
            commit_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
          wcnt_nxt_s = 16'd0;
          ovf_nxt_s  = 1'b0;
          w_nxt_s    = W_IDLE;
        end else if (i_rec_dvalid) begin
          if (wcnt_r == MAX_LEN_C) begin
            ovf_nxt_s = 1'b1;
          end else begin
            we_s       = 1'b1;
            waddr_s    = wcnt_r[ADDR_W-1:0];
            wcnt_nxt_s = wcnt_r + 16'd1;
          end
        end else begin
          w_nxt_s = W_FILL;
        end
      end
      W_DROP: begin
        if (done_evt_s) begin
          w_nxt_s = W_IDLE;
        end else begin
          w_nxt_s = W_DROP;
        end
      end
      default: begin
        w_nxt_s = W_IDLE;
      end
    endcase
  end

  // Bank RAM write port; contents are intentionally left unreset.
  always_ff @(posedge i_gmii_rx_clk) begin
    if (we_s) begin
      mem_r[wr_bank_r][waddr_s] <= i_rec_data;
    end
  end

  // Write-side bookkeeping, bank flags and error/drop counters.
  // Commit and release always target different banks, so both apply.
  always_ff @(posedge i_gmii_rx_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      wcnt_r     <= 16'd0;
      ovf_r      <= 1'b0;
      wr_bank_r  <= 1'b0;
      full_r     <= 2'b00;
      len_r[0]   <= 16'd0;
      len_r[1]   <= 16'd0;
      drop_cnt_r <= 16'd0;
      err_cnt_r  <= 16'd0;
    end else begin
      wcnt_r <= wcnt_nxt_s;
      ovf_r  <= ovf_nxt_s;
      if (commit_s) begin
        full_r[wr_bank_r] <= 1'b1;
        len_r[wr_bank_r]  <= wcnt_r;
        wr_bank_r         <= ~wr_bank_r;
      end
      if (release_s) begin
        full_r[rd_bank_r] <= 1'b0;
      end
      if (drop_s) begin
        drop_cnt_r <= sat_inc(drop_cnt_r);
      end
      if (err_s) begin
        err_cnt_r <= sat_inc(err_cnt_r);
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge i_gmii_rx_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      r_st_r <= R_IDLE;
    end else begin
      r_st_r <= r_nxt_s;
    end
  end

  // Read FSM: prefetch the next byte on every transfer so the stream has no bubbles.
  always_comb begin
    r_nxt_s     = r_st_r;
    ren_s       = 1'b0;
    raddr_s     = rptr_r;
    rptr_nxt_s  = rptr_r;
    start_s     = 1'b0;
    release_s   = 1'b0;
    valid_nxt_s = valid_r;
    case (r_st_r)
      R_IDLE: begin
        if (full_r[rd_bank_r]) begin
          ren_s      = 1'b1;
          raddr_s    = 16'd0;
          rptr_nxt_s = 16'd1;
          start_s    = 1'b1;
          r_nxt_s    = R_LOAD;
        end else begin
          r_nxt_s = R_IDLE;
        end
      end
      R_LOAD: begin
        valid_nxt_s = 1'b1;
        r_nxt_s     = R_SEND;
      end
      R_SEND: begin
        if (valid_r && pkt.i_pkt_ready) begin
          if (last_r) begin
            release_s   = 1'b1;
            valid_nxt_s = 1'b0;
            r_nxt_s     = R_IDLE;
          end else begin
            ren_s      = 1'b1;
            rptr_nxt_s = rptr_r + 16'd1;
          end
        end else begin
          r_nxt_s = R_SEND;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        r_nxt_s     = R_IDLE;
      end
    endcase
  end

  assign last_s = (raddr_s == (len_r[rd_bank_r] - 16'd1));

  // Output registers: data/last only move on a read, so they hold during stalls.
  always_ff @(posedge i_gmii_rx_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      rd_bank_r <= 1'b0;
      rptr_r    <= 16'd0;
      valid_r   <= 1'b0;
      last_r    <= 1'b0;
      rdata_r   <= 8'd0;
      pkt_len_r <= 16'd0;
    end else begin
      rptr_r  <= rptr_nxt_s;
      valid_r <= valid_nxt_s;
      if (ren_s) begin
        rdata_r <= mem_r[rd_bank_r][raddr_s[ADDR_W-1:0]];
        last_r  <= last_s;
      end
      if (start_s) begin
        pkt_len_r <= len_r[rd_bank_r];
      end
      if (release_s) begin
        rd_bank_r <= ~rd_bank_r;
        last_r    <= 1'b0;
        pkt_len_r <= 16'd0;
      end
    end
  end

  assign pkt.o_pkt_valid = valid_r;
  assign pkt.o_pkt_data  = rdata_r;
  assign pkt.o_pkt_last  = last_r;
  assign pkt.o_pkt_len   = pkt_len_r;
  assign o_drop_cnt      = drop_cnt_r;
  assign o_err_cnt       = err_cnt_r;
  assign o_bank_full     = full_r;

endmodule
